round_key_bank: RTL
===================

Name: round_key_bank

Overview:
- Multi-context AES round-key store. Holds up to KEY_SLOTS independently loaded key schedules (AES-128/192/256).
- Sits between the key expanders and the encryptor datapath.
- Loads are a validated, in-order write stream with a ready/valid handshake. Per-slot valid flags and key lengths are tracked.
- Reads are registered, with range/validity checking, so the encryptor can switch contexts without re-expansion.

Parameters:
- KEY_SLOTS, 2, number of independent key-schedule contexts (1..16).
- SLOT_W, $clog2(KEY_SLOTS) with minimum 1, slot-index width (derived localparam, not overridable).

Ports:
- mclk  in  1  master clock
- arst_n  in  1  asynchronous active-low reset
- load_start  in  1  begin loading a schedule
- load_slot  in  SLOT_W  target slot for load_start
- load_klen  in  2  00=128 (NR=10), 01=192 (NR=12), 10=256 (NR=14), 11 reserved
- wr_valid  in  1  expander presents a round key
- wr_ready  out  1  bank accepts a round key
- wr_index  in  4  round-key index of wr_key
- wr_key  in  [0:127]  round key
- load_done  out  1  one-cycle pulse: schedule complete, slot valid
- load_err  out  1  one-cycle pulse: load rejected/aborted
- busy  out  1  load in progress
- slot_clr  in  1  invalidate a slot
- clr_slot  in  SLOT_W  slot to invalidate
- slot_valid  out  KEY_SLOTS  per-slot schedule-complete flags
- rd_req  in  1  read request
- rd_slot  in  SLOT_W  read slot
- rd_round  in  4  read round index
- rd_key  out  [0:127]  round key read data
- rd_ack  out  1  read response strobe
- rd_err  out  1  read response invalid

Behaviour:
- Reset (async, arst_n=0): FSM to IDLE; all key registers, slot_valid, per-slot klen, rd_key, rd_ack, rd_err, load_done, load_err cleared to 0. Reset mid-load discards the load; the slot stays invalid.
- Storage: KEY_SLOTS x 15 x 128-bit registers. Per-slot 2-bit klen register.
- FSM states: IDLE, LOAD.
- IDLE + load_start, klen valid:
  - latch slot and klen; clear slot_valid[load_slot] the same edge; expected index = 0; go to LOAD.
- IDLE + load_start, klen=11: load_err pulse next cycle; no state change; slot untouched.
- LOAD:
  - wr_ready=1, busy=1. wr_ready=0 and busy=0 in IDLE.
  - Transfer occurs when wr_valid & wr_ready.
  - Transfer with wr_index==expected: write wr_key to [slot][index], increment expected.
  - If the written index == NR: set slot_valid, store klen, load_done pulse next cycle, go to IDLE.
  - Transfer with wr_index!=expected: nothing written; load_err pulse; go to IDLE; slot remains invalid.
  - load_start while in LOAD: ignored.
- slot_clr:
  - Clears slot_valid[clr_slot] next edge, in any state.
  - If clr_slot equals the slot being loaded, the load aborts: load_err pulse, go to IDLE.
  - Same-cycle final transfer and clear of that slot: the clear wins, so the slot ends invalid and load_err pulses, not load_done.
- Read:
  - Latency 1. rd_req sampled at edge N gives rd_ack=1 in cycle N+1.
  - rd_key = stored key if slot_valid[rd_slot] and rd_round <= NR(slot klen); otherwise rd_key=0 and rd_err=1.
  - rd_ack/rd_err are low when no request is made; rd_key holds its last value.
  - Reads are fully independent of the load FSM. Reading a slot under load returns rd_err, because that slot's valid flag was cleared at load_start.
  - rd_slot >= KEY_SLOTS (non-power-of-two configs) gives rd_err.
- Back-to-back: one write per cycle accepted. A new load_start is accepted the cycle after returning to IDLE.

Test Plan:
- Reset, then load_start slot0 klen=00, stream indices 0..10 with key[i]=i replicated -> load_done one cycle after index-10 transfer; slot_valid=2'b01; read slot0 round 10 -> rd_ack=1, rd_err=0, rd_key=0x0A..0A one cycle later.
- Read slot0 round 11 (AES-128 slot) and slot1 round 0 (unloaded) -> rd_ack=1, rd_err=1, rd_key=0 each.
- Load slot1 klen=10 with indices 0..14 while continuously reading slot0 round 5 -> slot0 reads unaffected; slot1 round 14 readable after load_done; slot_valid=2'b11.
- During a klen=01 load, send indices 0,1,3 -> load_err on the index-3 transfer; busy drops; slot invalid; reading round 1 -> rd_err=1.
- Mid-load slot_clr of the loading slot, plus load_start klen=11 in IDLE -> load_err each time; FSM IDLE; slot_valid bit 0.
- Assert arst_n low at index 7 of an AES-256 load -> all outputs 0 immediately; after release a fresh load of the same slot completes normally.

Source files
------------

// File: rtl/round_key_bank.sv
`default_nettype none
// ============================================================================
// Module   : round_key_bank
// Brief    : Multi-context AES round-key store with in-order validated loads
//            and registered, range-checked reads.
// Revision : 1.0 - initial release
// ============================================================================
module round_key_bank #(
    parameter  int KEY_SLOTS = 2,
    localparam int SLOT_W    = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
    input  logic              mclk,
    input  logic              arst_n,
    input  logic              load_start,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic [1:0]        load_klen,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_index,
    input  logic [0:127]      wr_key,
    output logic              load_done,
    output logic              load_err,
    output logic              busy,
    input  logic              slot_clr,
    input  logic [SLOT_W-1:0] clr_slot,
    output logic [KEY_SLOTS-1:0] slot_valid,
    input  logic              rd_req,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [3:0]        rd_round,
    output logic [0:127]      rd_key,
    output logic              rd_ack,
    output logic              rd_err
);

    localparam int C_ROUNDS = 15;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [1:0]          r_klen;
    logic [3:0]          r_exp;
    logic [KEY_SLOTS-1:0] r_valid;
    logic [1:0]          r_klen_s [KEY_SLOTS];
    logic [0:127]        r_mem    [KEY_SLOTS][C_ROUNDS];
    logic                r_done;
    logic                r_err;
    logic [0:127]        r_rd_key;
    logic                r_rd_ack;
    logic                r_rd_err;

    logic                w_ld_slot_ok;
    logic                w_abort;
    logic                w_rd_ok;
    logic [0:127]        w_rd_data;

    function automatic logic [3:0] f_nr(input logic [1:0] k);
        case (k)
            2'b00:   f_nr = 4'd10;
            2'b01:   f_nr = 4'd12;
            2'b10:   f_nr = 4'd14;
            default: f_nr = 4'd0;
        endcase
    endfunction

    assign wr_ready   = (r_state == S_LOAD);
    assign busy       = (r_state == S_LOAD);
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign slot_valid = r_valid;
    assign rd_key     = r_rd_key;
    assign rd_ack     = r_rd_ack;
    assign rd_err     = r_rd_err;

    // A clear aimed at the slot under load kills the load, even on its final beat.
    assign w_abort = (r_state == S_LOAD) && slot_clr && (clr_slot == r_slot);

    always_comb begin
        w_ld_slot_ok = 1'b0;
        w_rd_ok      = 1'b0;
        w_rd_data    = '0;
        for (int s = 0; s < KEY_SLOTS; s++) begin
            if (load_slot == SLOT_W'(s)) w_ld_slot_ok = 1'b1;
            if (rd_slot == SLOT_W'(s)) begin
                if (r_valid[s] && (rd_round <= f_nr(r_klen_s[s]))) w_rd_ok = 1'b1;
                for (int r = 0; r < C_ROUNDS; r++) begin
                    if (rd_round == 4'(r)) w_rd_data = r_mem[s][r];
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_klen   <= '0;
            r_exp    <= '0;
            r_valid  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_key <= '0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
            for (int s = 0; s < KEY_SLOTS; s++) begin
                r_klen_s[s] <= '0;
                for (int r = 0; r < C_ROUNDS; r++) r_mem[s][r] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        if ((load_klen == 2'b11) || !w_ld_slot_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_slot  <= load_slot;
                            r_klen  <= load_klen;
                            r_exp   <= '0;
                            r_state <= S_LOAD;
                            for (int s = 0; s < KEY_SLOTS; s++) begin
                                if (load_slot == SLOT_W'(s)) r_valid[s] <= 1'b0;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (wr_valid) begin
                        if (wr_index == r_exp) begin
                            for (int s = 0; s < KEY_SLOTS; s++) begin
                                for (int r = 0; r < C_ROUNDS; r++) begin
                                    if ((r_slot == SLOT_W'(s)) && (r_exp == 4'(r)))
                                        r_mem[s][r] <= wr_key;
                                end
                            end
                            r_exp <= r_exp + 4'd1;
                            if (r_exp == f_nr(r_klen)) begin
                                for (int s = 0; s < KEY_SLOTS; s++) begin
                                    if (r_slot == SLOT_W'(s)) begin
                                        r_valid[s]  <= 1'b1;
                                        r_klen_s[s] <= r_klen;
                                    end
                                end
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed after the load logic so an explicit clear overrides a set.
            if (slot_clr) begin
                for (int s = 0; s < KEY_SLOTS; s++) begin
                    if (clr_slot == SLOT_W'(s)) r_valid[s] <= 1'b0;
                end
            end

            if (rd_req) begin
                r_rd_ack <= 1'b1;
                r_rd_err <= !w_rd_ok;
                r_rd_key <= w_rd_ok ? w_rd_data : '0;
            end else begin
                r_rd_ack <= 1'b0;
                r_rd_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
